clock_set_ctrl: RTL and testbench

//  Mode sequencer for the clock's time-set datapath. Debounces the raw MODE/INC/DEC/LEFT/RIGHT

---
 rtl/clock_set_ctrl_if.sv | 32 +++
 rtl/clock_set_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_set_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clock_set_ctrl_if : buttons/tick in, time-set control outputs out      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface clock_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic       btn_left;
  logic       btn_right;
  logic       tick_1hz;
  logic       set_en;
  logic       inc_p;
  logic       dec_p;
  logic       left_p;
  logic       right_p;
  logic       run_en;
  logic       load_time;
  logic [1:0] state_o;

  modport master (
    output btn_mode, btn_inc, btn_dec, btn_left, btn_right, tick_1hz,
    input  set_en, inc_p, dec_p, left_p, right_p, run_en, load_time, state_o
  );

  modport slave (
    input  btn_mode, btn_inc, btn_dec, btn_left, btn_right, tick_1hz,
    output set_en, inc_p, dec_p, left_p, right_p, run_en, load_time, state_o
  );
endinterface
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clock_set_ctrl : button debounce + RUN/ENTER/EDIT/COMMIT sequencer     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module clock_set_ctrl #(
  parameter int DB_CYCLES  = 4,
  parameter int TIMEOUT_S  = 10,
  parameter int COMMIT_DLY = 2
) (
  input  logic             MCLK,
  input  logic             RESET,
  clock_set_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_ENTER  = 2'b01,
    ST_EDIT   = 2'b10,
    ST_COMMIT = 2'b11
  } state_t;

  localparam int NB = 5;  // bit order: mode, inc, dec, left, right (priority high->low)

  logic [NB-1:0] raw_w;
  logic [NB-1:0] press_w;

  assign raw_w = {bus.btn_right, bus.btn_left, bus.btn_dec, bus.btn_inc, bus.btn_mode};

  generate
    for (genvar g = 0; g < NB; g++) begin : g_btn
      logic        sync1_q, sync2_q;
      logic        level_q, level_d;
      logic        press_q, press_d;
      logic [15:0] cnt_q, cnt_d;

      // Any sample equal to the current level restarts the stability count.
      always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
          if (cnt_q == 16'(DB_CYCLES - 1)) begin
            level_d = sync2_q;
            press_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          level_q <= 1'b0;
          press_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= raw_w[g];
          sync2_q <= sync1_q;
          level_q <= level_d;
          press_q <= press_d;
          cnt_q   <= cnt_d;
        end
      end

      assign press_w[g] = press_q;
    end
  endgenerate

  state_t     state_q, state_d;
  logic [7:0] tmr_q, tmr_d;
  logic [5:0] idle_q, idle_d, idle_nx;
  logic       set_en_q, set_en_d;
  logic       run_en_q, run_en_d;
  logic       inc_q, inc_d, dec_q, dec_d, left_q, left_d, right_q, right_d;
  logic       load_q, load_d;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idle_d  = idle_q;
    idle_nx = idle_q + {5'd0, bus.tick_1hz};
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    left_d  = 1'b0;
    right_d = 1'b0;
    load_d  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (press_w[0]) begin
          state_d = ST_ENTER;
          tmr_d   = '0;
        end
      end
      ST_ENTER: begin
        if (tmr_q == 8'd1) begin
          state_d = ST_EDIT;
          tmr_d   = '0;
          idle_d  = '0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      ST_EDIT: begin
        // Timeout has precedence over a press accepted in the same cycle.
        if (idle_nx == 6'(TIMEOUT_S)) begin
          state_d = ST_RUN;
          idle_d  = '0;
        end else if (press_w[0]) begin
          state_d = ST_COMMIT;
          tmr_d   = '0;
          idle_d  = '0;
        end else if (press_w[1]) begin
          inc_d  = 1'b1;
          idle_d = '0;
        end else if (press_w[2]) begin
          dec_d  = 1'b1;
          idle_d = '0;
        end else if (press_w[3]) begin
          left_d = 1'b1;
          idle_d = '0;
        end else if (press_w[4]) begin
          right_d = 1'b1;
          idle_d  = '0;
        end else begin
          idle_d = idle_nx;
        end
      end
      ST_COMMIT: begin
        if (tmr_q == 8'(COMMIT_DLY)) begin
          state_d = ST_RUN;
          tmr_d   = '0;
        end else begin
          tmr_d  = tmr_q + 8'd1;
          load_d = (tmr_q == 8'(COMMIT_DLY - 1));
        end
      end
      default: state_d = ST_RUN;
    endcase
    set_en_d = (state_d != ST_RUN);
    run_en_d = (state_d == ST_RUN);
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_RUN;
      tmr_q    <= '0;
      idle_q   <= '0;
      set_en_q <= 1'b0;
      run_en_q <= 1'b1;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      idle_q   <= idle_d;
      set_en_q <= set_en_d;
      run_en_q <= run_en_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      left_q   <= left_d;
      right_q  <= right_d;
      load_q   <= load_d;
    end
  end

  assign bus.set_en    = set_en_q;
  assign bus.run_en    = run_en_q;
  assign bus.inc_p     = inc_q;
  assign bus.dec_p     = dec_q;
  assign bus.left_p    = left_q;
  assign bus.right_p   = right_q;
  assign bus.load_time = load_q;
  assign bus.state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_clock_set_ctrl : directed + random bench with behavioural model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_clock_set_ctrl;
  localparam int DB = 4;
  localparam int TO = 3;
  localparam int CD = 2;

  logic MCLK  = 1'b0;
  logic RESET = 1'b1;
  always #5 MCLK = ~MCLK;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(.DB_CYCLES(DB), .TIMEOUT_S(TO), .COMMIT_DLY(CD)) dut (
    .MCLK  (MCLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: mode 0 RUN, 1 ENTER, 2 EDIT, 3 COMMIT
  int       m_mode, m_age, m_idle;
  int       m_run [5];
  bit [4:0] m_lvl, m_press, m_pulse;
  bit       m_load;
  bit [4:0] dly[$];

  int c_inc, c_dec, c_left, c_right, c_load, c_enter;
  int t_inc, t_left, t_load, t_commit;
  logic [1:0] prev_state;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_idle = 0;
    for (int b = 0; b < 5; b++) m_run[b] = 0;
    m_lvl = '0; m_press = '0; m_pulse = '0; m_load = 1'b0;
    dly.delete();
    dly.push_back(5'd0);
    dly.push_back(5'd0);
  endtask

  task automatic model_edge();
    int       sel;
    int       ni;
    bit [4:0] raw, s;
    sel = -1;
    for (int b = 0; b < 5; b++) if (m_press[b] && sel < 0) sel = b;
    m_pulse = '0;
    m_load  = 1'b0;
    case (m_mode)
      0: if (sel == 0) begin m_mode = 1; m_age = 0; end
      1: if (m_age == 1) begin m_mode = 2; m_idle = 0; end else m_age++;
      2: begin
        ni = m_idle + int'(bus.tick_1hz);
        if (ni >= TO) m_mode = 0;
        else if (sel == 0) begin m_mode = 3; m_age = 0; end
        else if (sel > 0) begin m_pulse[sel] = 1'b1; m_idle = 0; end
        else m_idle = ni;
      end
      default: begin
        if (m_age == CD - 1) m_load = 1'b1;
        if (m_age == CD) m_mode = 0; else m_age++;
      end
    endcase
    // Debounced levels follow the button as seen two clocks late.
    raw = {bus.btn_right, bus.btn_left, bus.btn_dec, bus.btn_inc, bus.btn_mode};
    dly.push_back(raw);
    s = dly.pop_front();
    m_press = '0;
    for (int b = 0; b < 5; b++) begin
      if (s[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          m_lvl[b] = s[b]; m_run[b] = 0; m_press[b] = s[b];
        end
      end else m_run[b] = 0;
    end
  endtask

  function automatic logic [8:0] obs_v();
    return {bus.state_o, bus.set_en, bus.run_en, bus.inc_p, bus.dec_p,
            bus.left_p, bus.right_p, bus.load_time};
  endfunction

  function automatic logic [8:0] exp_v();
    return {2'(m_mode), m_mode != 0, m_mode == 0, m_pulse[1], m_pulse[2],
            m_pulse[3], m_pulse[4], m_load};
  endfunction

  task automatic clear_stats();
    c_inc = 0; c_dec = 0; c_left = 0; c_right = 0; c_load = 0; c_enter = 0;
    t_inc = -1; t_left = -1; t_load = -1; t_commit = -1;
  endtask

  task automatic step();
    @(posedge MCLK);
    if (RESET) model_reset(); else model_edge();
    #1;
    cyc++;
    chk("outputs", 32'(obs_v()), 32'(exp_v()));
    if (bus.inc_p)   begin c_inc++;  t_inc  = cyc; end
    if (bus.dec_p)   c_dec++;
    if (bus.left_p)  begin c_left++; t_left = cyc; end
    if (bus.right_p) c_right++;
    if (bus.load_time) begin c_load++; t_load = cyc; end
    if (bus.state_o == 2'b01) c_enter++;
    if (bus.state_o == 2'b11 && prev_state != 2'b11) t_commit = cyc;
    prev_state = bus.state_o;
  endtask

  task automatic set_btn(bit [4:0] v);
    bus.btn_mode  = v[0];
    bus.btn_inc   = v[1];
    bus.btn_dec   = v[2];
    bus.btn_left  = v[3];
    bus.btn_right = v[4];
  endtask

  task automatic goto_edit();
    set_btn(5'b00001);
    repeat (10) step();
    set_btn(5'b00000);
    repeat (12) step();
    chk("goto_edit_state", 32'(bus.state_o), 32'd2);
  endtask

  initial begin
    int tp, tr;
    bit [4:0] rb;
    bit       found;
    set_btn(5'b00000);
    bus.tick_1hz = 1'b0;
    prev_state = 2'b00;
    model_reset();
    clear_stats();

    // 1: reset values, then a mode press through ENTER into EDIT
    repeat (3) step();
    chk("reset_state", 32'(bus.state_o), 32'd0);
    chk("reset_run_en", 32'(bus.run_en), 32'd1);
    chk("reset_set_en", 32'(bus.set_en), 32'd0);
    RESET = 1'b0;
    clear_stats();
    goto_edit();
    chk("enter_len", 32'(c_enter), 32'd2);
    chk("edit_set_en", 32'(bus.set_en), 32'd1);
    chk("edit_run_en", 32'(bus.run_en), 32'd0);

    // 2: single inc then single left, 7-cycle latency each
    clear_stats();
    set_btn(5'b00010); tp = cyc; repeat (10) step();
    set_btn(5'b00000); repeat (10) step();
    chk("inc_count", 32'(c_inc), 32'd1);
    chk("inc_latency", 32'(t_inc - tp), 32'd7);
    set_btn(5'b01000); tp = cyc; repeat (10) step();
    set_btn(5'b00000); repeat (10) step();
    chk("left_count", 32'(c_left), 32'd1);
    chk("left_latency", 32'(t_left - tp), 32'd7);

    // 3: bouncing inc, then held high
    clear_stats();
    tr = cyc;
    for (int i = 0; i < 20; i++) begin
      set_btn(((i / 2) % 2) != 0 ? 5'b00010 : 5'b00000);
      if (i % 4 == 2) tr = cyc;
      step();
    end
    repeat (12) step();
    set_btn(5'b00000); repeat (10) step();
    chk("bounce_inc_count", 32'(c_inc), 32'd1);
    chk("bounce_inc_latency", 32'(t_inc - tr), 32'd7);

    // 4: inc+dec together, then mode+inc together
    clear_stats();
    set_btn(5'b00110); repeat (10) step();
    set_btn(5'b00000); repeat (10) step();
    chk("incdec_inc", 32'(c_inc), 32'd1);
    chk("incdec_dec", 32'(c_dec), 32'd0);
    clear_stats();
    set_btn(5'b00011); repeat (10) step();
    set_btn(5'b00000); repeat (10) step();
    chk("modeinc_inc", 32'(c_inc), 32'd0);
    chk("modeinc_load", 32'(c_load), 32'd1);
    chk("modeinc_state", 32'(bus.state_o), 32'd0);

    // 5: commit timing
    goto_edit();
    clear_stats();
    set_btn(5'b00001);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = bus.load_time;
    end
    chk("load_seen", 32'(found), 32'd1);
    chk("load_delay", 32'(t_load - t_commit), 32'd2);
    step();
    chk("run_after_load_en", 32'(bus.run_en), 32'd1);
    chk("run_after_load_state", 32'(bus.state_o), 32'd0);
    chk("load_width", 32'(bus.load_time), 32'd0);
    set_btn(5'b00000); repeat (10) step();

    // 6a: timeout cancels edit
    goto_edit();
    clear_stats();
    for (int k = 0; k < TO; k++) begin
      bus.tick_1hz = 1'b1; step();
      bus.tick_1hz = 1'b0; repeat (4) step();
    end
    chk("timeout_state", 32'(bus.state_o), 32'd0);
    chk("timeout_load", 32'(c_load), 32'd0);

    // 6b: reset while in COMMIT
    goto_edit();
    clear_stats();
    set_btn(5'b00001);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = (bus.state_o == 2'b11);
    end
    chk("commit_seen", 32'(found), 32'd1);
    RESET = 1'b1;
    set_btn(5'b00000);
    #1;
    model_reset();
    chk("async_reset", 32'(obs_v()), 32'(exp_v()));
    step();
    RESET = 1'b0;
    repeat (10) step();
    chk("reset_commit_load", 32'(c_load), 32'd0);
    chk("reset_commit_state", 32'(bus.state_o), 32'd0);

    // Random phase against the model
    rb = '0;
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(7) == 0) rb[b] = ~rb[b];
      set_btn(rb);
      bus.tick_1hz = ($urandom_range(19) == 0);
      RESET = ($urandom_range(999) == 0);
      step();
    end
    RESET = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
